// File: rtl/axis_packetizer_if.sv
// AXI-Stream style link: data, valid, last and ready.
// master drives the beat, slave returns ready.
interface axis_packetizer_if #(
  parameter int DW = 8
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_packetizer.sv
// Fixed-length packet framer: one header beat carrying len, then len
// payload beats (zero-padded on early input tlast), then k idle cycles.
module axis_packetizer #(
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst,
  axis_packetizer_if.slave  s,
  axis_packetizer_if.master m,
  input  logic [2*DW-1:0]   packet_config,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, DATA, PAD, GAP} state_t;

  state_t        state_reg;
  logic [DW-1:0] cnt_reg;
  logic [DW-1:0] len_q;
  logic [DW-1:0] k_q;
  logic [DW-1:0] gap_reg;
  logic [DW-1:0] m_tdata_reg;
  logic          m_tvalid_reg;
  logic          m_tlast_reg;

  logic [DW-1:0] cfg_len;
  logic [DW-1:0] cfg_k;
  logic          m_free;
  logic          last_beat;

  assign cfg_len   = packet_config[2*DW-1:DW];
  assign cfg_k     = packet_config[DW-1:0];
  // The output register can take a new beat when empty or draining this cycle.
  assign m_free    = ~m_tvalid_reg | m.tready;
  assign last_beat = (cnt_reg == len_q - DW'(1));

  // Input is only ever accepted in DATA, and only when the output can take it.
  assign s.tready  = (state_reg == DATA) && m_free;
  assign busy      = (state_reg != IDLE);

  assign m.tdata   = m_tdata_reg;
  assign m.tvalid  = m_tvalid_reg;
  assign m.tlast   = m_tlast_reg;

  // Framing FSM with registered output beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      len_q        <= '0;
      k_q          <= '0;
      gap_reg      <= '0;
      m_tdata_reg  <= '0;
      m_tvalid_reg <= 1'b0;
      m_tlast_reg  <= 1'b0;
    end else begin
      // A completed handshake empties the register unless a new beat loads below.
      if (m_tvalid_reg && m.tready) begin
        m_tvalid_reg <= 1'b0;
        m_tlast_reg  <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          // len of zero keeps the block parked here.
          if (s.tvalid && (cfg_len != '0) && m_free) begin
            len_q        <= cfg_len;
            k_q          <= cfg_k;
            m_tdata_reg  <= cfg_len;
            m_tvalid_reg <= 1'b1;
            m_tlast_reg  <= 1'b0;
            cnt_reg      <= '0;
            state_reg    <= DATA;
          end
        end

        DATA: begin
          if (s.tvalid && m_free) begin
            m_tdata_reg  <= s.tdata;
            m_tvalid_reg <= 1'b1;
            m_tlast_reg  <= last_beat;
            cnt_reg      <= cnt_reg + DW'(1);
            if (last_beat) begin
              if (k_q != '0) begin
                gap_reg   <= k_q;
                state_reg <= GAP;
              end else begin
                state_reg <= IDLE;
              end
            end else if (s.tlast) begin
              state_reg <= PAD;
            end
          end
        end

        PAD: begin
          if (m_free) begin
            m_tdata_reg  <= '0;
            m_tvalid_reg <= 1'b1;
            m_tlast_reg  <= last_beat;
            cnt_reg      <= cnt_reg + DW'(1);
            if (last_beat) begin
              if (k_q != '0) begin
                gap_reg   <= k_q;
                state_reg <= GAP;
              end else begin
                state_reg <= IDLE;
              end
            end
          end
        end

        GAP: begin
          // Counting starts on the edge that retires the final beat, so the
          // output stays empty for exactly k cycles before the next header.
          if (m_free) begin
            if (gap_reg == DW'(1)) begin
              state_reg <= IDLE;
            end else begin
              gap_reg <= gap_reg - DW'(1);
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
